vga_color_capture: RTL and testbench
====================================

Name: vga_color_capture

Overview:
- Receive-side counterpart of the 32-bit-word-to-pixel colour serialiser.
- Samples the 12-bit RGB pixel stream (4 bits each colour) during valid.
- Slices each pixel to one bit (white=1, black=0) and packs 32 consecutive pixels MSB-first into a 32-bit word.
- Delivers each word through a one-entry valid/ready output buffer. Used for loopback checking of the VGA path and for capturing bit patterns back into the CPU/Ethernet datapath.

Parameters:
- THRESH, 23, bit decision: pixel bit = 1 when red+green+blue (6-bit sum, 0..45) >= THRESH.
- WORD_W, 32, packed word width. Fixed at 32; the counter width is 5.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid  input  1  pixel stream active; one pixel per clk while high.
- red  input  4  pixel red component.
- green  input  4  pixel green component.
- blue  input  4  pixel blue component.
- word_out  output  32  packed word; the first sampled pixel is bit 31.
- word_valid  output  1  word_out holds an untransferred word.
- word_ready  input  1  consumer accepts word_out at an edge where word_valid=1.
- runt  output  1  one-cycle pulse: valid fell with a partial word (1..31 pixels) pending.
- overflow  output  1  sticky; a completed word was dropped because the buffer was full.

Behaviour:
- Reset: rst sampled high at a clk edge clears count=0, shreg=0, word_out=0, word_valid=0, runt=0, overflow=0. Reset mid-word discards the partial word with no runt pulse. Reset also discards a held word.
- Bit slice:
  - bit = ({2'b0,red}+{2'b0,green}+{2'b0,blue} >= THRESH).
  - 6-bit unsigned arithmetic, no overflow possible.
- Collection:
  - valid=1 at an edge: shreg <= {shreg[30:0], bit}; count <= count+1, wrapping 31->0.
  - Pixel index k of the word (0..31) lands in final bit 31-k.
- Completion:
  - The edge sampling pixel 31 (count==31) completes the word {shreg[30:0],bit}.
  - If the buffer is empty, or being transferred at that same edge (word_valid&&word_ready), the word is loaded into word_out and word_valid=1 from the next cycle.
  - Latency: word_valid rises the cycle after the 32nd pixel edge.
  - If the buffer is full and word_ready=0 at that edge, the new word is dropped, word_out is unchanged, and overflow <= 1. Overflow stays set until rst.
- Transfer: at an edge with word_valid&&word_ready and no simultaneous completion, word_valid <= 0. word_out holds its last value.
- Back-to-back words: valid held high continuously produces one word per 32 cycles. Collection never stalls; there is no backpressure on the pixel stream.
- valid low at an edge:
  - count <= 0 and shreg <= 0.
  - If count was 1..31 (partial word), runt <= 1 for exactly one cycle; otherwise runt <= 0.
  - valid low with count==0 produces no runt.
- runt defaults to 0 every cycle in which the condition above does not occur.
- Two-phase view:
  - COLLECT: count 0..31 while valid is high.
  - IDLE: count=0 while valid is low.
  - The output buffer runs as an independent EMPTY/FULL state machine:
    - EMPTY->FULL on completion.
    - FULL->EMPTY on transfer without completion.
    - FULL->FULL on completion plus transfer (load) or on completion without transfer (drop).

Decomposition:
- Shared package vga_pkg: COLOR_W=4, WORD_W=32, CNT_W=5, SUM_W=6, WHITE=4'hF, BLACK=4'h0. The same constants are shared with the transmit-side colour block.
- One sub-module: vga_bit_slicer (combinational RGB-to-bit threshold, parameter THRESH). The counter, shift register and output buffer stay in the top level.

Test Plan:
- Loopback: drive the transmit-side colour output for data 32'hA5A5_0F0F with valid held 32 cycles, word_ready=1 -> word_out=32'hA5A5_0F0F, word_valid high for exactly 1 cycle, starting the cycle after the 32nd pixel.
- Threshold: R,G,B = 7,8,8 (sum 23) for 32 pixels -> 32'hFFFF_FFFF; R,G,B = 7,8,7 (sum 22) -> 32'h0000_0000.
- Backpressure:
  - 64 pixels all white, word_ready=0 throughout -> first word 32'hFFFF_FFFF held, second word dropped, overflow=1.
  - Then word_ready=1 -> one transfer, word_valid falls.
  - overflow stays 1 until rst.
- Simultaneous: the first word is held, and word_ready pulses high exactly on the edge completing the second word (pattern 32'h1234_5678) -> word_out=32'h1234_5678, word_valid stays 1, overflow=0.
- Runt: valid high 10 pixels then low -> runt=1 for one cycle, no word_valid. A following full 32-pixel word of 32'hDEAD_BEEF is captured correctly (count restarted at 0).
- Reset mid-word: rst high for 1 cycle after 20 pixels, with a held word present -> word_valid=0, word_out=0, runt=0. The next 32 pixels yield the correct word.

Source files
------------

// File: rtl/vga_pkg.sv
// Constants and types shared by the VGA colour transmit and capture blocks.
// Widths are fixed: a 32-bit word maps to 32 pixels, so the pixel counter is 5 bits.
package vga_pkg;

  localparam int COLOR_W = 4;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 5;
  localparam int SUM_W   = 6;

  localparam logic [COLOR_W-1:0] WHITE = 4'hF;
  localparam logic [COLOR_W-1:0] BLACK = 4'h0;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/vga_color_capture_if.sv
// Pixel-in / word-out bus of the colour capture block.
// The master drives pixels and word_ready; the slave (capture block) returns words and status.
interface vga_color_capture_if;

  logic                         valid;
  logic [vga_pkg::COLOR_W-1:0]  red;
  logic [vga_pkg::COLOR_W-1:0]  green;
  logic [vga_pkg::COLOR_W-1:0]  blue;
  logic [vga_pkg::WORD_W-1:0]   word_out;
  logic                         word_valid;
  logic                         word_ready;
  logic                         runt;
  logic                         overflow;

  modport master (
    output valid, red, green, blue, word_ready,
    input  word_out, word_valid, runt, overflow
  );

  modport slave (
    input  valid, red, green, blue, word_ready,
    output word_out, word_valid, runt, overflow
  );

endinterface

// File: rtl/vga_bit_slicer.sv
// Combinational RGB-to-bit threshold: 1 when red+green+blue >= THRESH.
// The 6-bit sum tops out at 45, so it never wraps.
module vga_bit_slicer
  import vga_pkg::*;
#(
  parameter int THRESH = 23
) (
  input  logic [COLOR_W-1:0] red_i,
  input  logic [COLOR_W-1:0] green_i,
  input  logic [COLOR_W-1:0] blue_i,
  output logic               bit_o
);

  logic [SUM_W-1:0] sum;

  assign sum   = {2'b0, red_i} + {2'b0, green_i} + {2'b0, blue_i};
  assign bit_o = (sum >= SUM_W'(THRESH));

endmodule

// File: rtl/vga_color_capture.sv
// Captures a 1-bit-per-pixel stream into 32-bit MSB-first words behind a one-entry
// valid/ready buffer; a completed word is dropped (sticky overflow) when the buffer stays full.
module vga_color_capture
  import vga_pkg::*;
#(
  parameter int THRESH = 23
) (
  input  logic                clk,
  input  logic                rst,
  vga_color_capture_if.slave  bus
);

  logic                pix_bit;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-2:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   word_q;
  logic [WORD_W-1:0]   new_word;
  logic                runt_q, runt_d;
  logic                ovf_q;
  logic                complete;
  buf_state_t          buf_q;

  vga_bit_slicer #(.THRESH(THRESH)) u_slicer (
    .red_i   (bus.red),
    .green_i (bus.green),
    .blue_i  (bus.blue),
    .bit_o   (pix_bit)
  );

  assign new_word = {shreg_q, pix_bit};
  assign complete = bus.valid && (count_q == CNT_W'(WORD_W - 1));

  always_comb begin
    count_d = '0;
    shreg_d = '0;
    runt_d  = 1'b0;
    if (bus.valid) begin
      count_d = count_q + CNT_W'(1);
      shreg_d = new_word[WORD_W-2:0];
    end else begin
      // A dropped valid with a partially filled word is flagged as a runt.
      runt_d  = (count_q != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      runt_q  <= 1'b0;
      ovf_q   <= 1'b0;
      buf_q   <= BUF_EMPTY;
    end else begin
      count_q <= count_d;
      shreg_q <= shreg_d;
      runt_q  <= runt_d;
      case (buf_q)
        BUF_EMPTY: begin
          if (complete) begin
            word_q <= new_word;
            buf_q  <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          // A transfer on the completing edge frees the slot just in time for the new word.
          if (complete) begin
            if (bus.word_ready) word_q <= new_word;
            else                ovf_q  <= 1'b1;
          end else if (bus.word_ready) begin
            buf_q <= BUF_EMPTY;
          end
        end
        default: buf_q <= BUF_EMPTY;
      endcase
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = (buf_q == BUF_FULL);
  assign bus.runt       = runt_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_vga_color_capture.sv
// Randomized and directed bench for vga_color_capture with a queue-based reference model
// and a per-cycle scoreboard checked on the falling edge.
module tb_vga_color_capture;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_color_capture_if bus();

  vga_color_capture #(.THRESH(23)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic        vld;
    logic        runt;
    logic        ovf;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pending pixel bits and a single held word.
  bit          pend[$];
  logic [31:0] m_word;
  logic        m_held;
  logic        m_runt;
  logic        m_ovf;

  task automatic model_edge(input logic r_st, input logic v, input int r, input int g,
                            input int b, input logic rdy);
    logic [31:0] w;
    if (r_st) begin
      pend.delete();
      m_word = '0; m_held = 1'b0; m_runt = 1'b0; m_ovf = 1'b0;
      return;
    end
    m_runt = 1'b0;
    if (m_held && rdy) m_held = 1'b0;
    if (v) begin
      pend.push_back((r + g + b) >= 23);
      if (pend.size() == 32) begin
        w = '0;
        foreach (pend[i]) w[31-i] = pend[i];
        pend.delete();
        if (!m_held) begin
          m_word = w;
          m_held = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end else begin
      m_runt = (pend.size() != 0);
      pend.delete();
    end
  endtask

  task automatic step(input logic r_st, input logic v, input logic [3:0] r,
                      input logic [3:0] g, input logic [3:0] b, input logic rdy);
    exp_t e;
    rst = r_st;
    bus.valid = v; bus.red = r; bus.green = g; bus.blue = b; bus.word_ready = rdy;
    @(posedge clk);
    model_edge(r_st, v, int'(r), int'(g), int'(b), rdy);
    e.word = m_word; e.vld = m_held; e.runt = m_runt; e.ovf = m_ovf;
    expq.push_back(e);
    #1;
  endtask

  task automatic pix(input logic bitv, input logic rdy);
    logic [3:0] c;
    c = bitv ? WHITE : BLACK;
    step(1'b0, 1'b1, c, c, c, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, rdy);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 31; i >= 0; i--) pix(w[i], rdy);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("word_valid", 32'(bus.word_valid), 32'(e.vld));
      chk("word_out",   bus.word_out,        e.word);
      chk("runt",       32'(bus.runt),       32'(e.runt));
      chk("overflow",   32'(bus.overflow),   32'(e.ovf));
    end
  end

  initial begin
    logic [31:0] sw;
    rst = 1'b1;
    bus.valid = 1'b0; bus.red = '0; bus.green = '0; bus.blue = '0; bus.word_ready = 1'b0;
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Loopback of a transmit-side colour pattern
    send_word(32'hA5A5_0F0F, 1'b1);
    idle(3, 1'b1);

    // Threshold boundary: sum 23 is white, sum 22 is black
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 4'd7, 4'd8, 4'd8, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 4'd7, 4'd8, 4'd7, 1'b1);
    idle(2, 1'b1);

    // Backpressure: second word dropped, overflow sticky
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Simultaneous transfer and completion
    send_word(32'hFFFF_FFFF, 1'b0);
    sw = 32'h1234_5678;
    for (int i = 31; i >= 0; i--) pix(sw[i], i == 0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // Runt followed by a clean word
    for (int i = 0; i < 10; i++) pix(1'b1, 1'b1);
    idle(2, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    idle(2, 1'b1);

    // Reset mid-word with a held word
    send_word(32'h0F0F_F0F0, 1'b0);
    for (int i = 0; i < 20; i++) pix(1'b1, 1'b0);
    step(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r_st;
      logic v;
      r_st = ($urandom_range(0, 499) == 0);
      v    = ($urandom_range(0, 99) < 93);
      step(r_st, v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end
    idle(2, 1'b1);

    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", expq.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
